// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param.
// The master side drives requests and write data; the slave side is the FIFO.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, din, rd_en,
    input  dout, full, empty, almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, full, empty, almost_full, almost_empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with registered flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input logic           clk,
  input logic           rst,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW-1:0]     wr_ptr_nx, rd_ptr_nx;
  logic [CW-1:0]     count_q, count_nx;
  logic [DATA_W-1:0] dout_q, dout_nx;
  logic              full_q, empty_q;
  logic              af_q, ae_q;
  logic              ovf_q, unf_q;
  logic              wr_ok, rd_ok;

  assign wr_ok = bus.wr_en && !full_q;
  assign rd_ok = bus.rd_en && !empty_q;

  always_comb begin
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_ptr;
    count_nx  = count_q;
    if (wr_ok) wr_ptr_nx = wr_ptr + AW'(1);
    if (rd_ok) rd_ptr_nx = rd_ptr + AW'(1);
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nx = count_q + CW'(1);
      2'b01:   count_nx = count_q - CW'(1);
      default: count_nx = count_q;
    endcase
  end

`ifdef FIFO_FWFT_EN
  // Head word may be the one being written this cycle.
  always_comb begin
    dout_nx = dout_q;
    if (count_nx != '0) begin
      if (wr_ok && (rd_ptr_nx == wr_ptr))
        dout_nx = bus.din;
      else
        dout_nx = mem[rd_ptr_nx];
    end
  end
`else
  always_comb begin
    dout_nx = dout_q;
    if (rd_ok) dout_nx = mem[rd_ptr];
  end
`endif

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nx;
      rd_ptr  <= rd_ptr_nx;
      count_q <= count_nx;
      dout_q  <= dout_nx;
      full_q  <= (count_nx == FULL_C);
      empty_q <= (count_nx == '0);
      af_q    <= (count_nx >= AF_C);
      ae_q    <= (count_nx <= AE_C);
      ovf_q   <= bus.wr_en && full_q;
      unf_q   <= bus.rd_en && empty_q;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule
